instr_fetch_unit: RTL

Front-end fetch stage directly upstream of the instruction cache controller. Owns the PC, issues one-at-a-time requests on the cache's req/ready/valid handshake, and holds the request address stable while a miss refills. Buffers returned instructions in a small queue toward decode, and handles execute-stage redirects by flushing the queue and discarding in-flight responses.

---
 rtl/multicore_pkg.sv | 29 ++
 rtl/instr_fetch_queue.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/multicore_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicore_pkg
//  Description : Shared types and constants for the core front end
//                (fetch FSM states, fetch packet, saturating increment).
//  Revision    : 1.0 - initial release
// ============================================================================
package multicore_pkg;

    localparam int INST_SIZE       = 32;
    localparam int FETCH_ADDR_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        DISCARD  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_SIZE-1:0] pc;
        logic [INST_SIZE-1:0]       instr;
    } fetch_pkt_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_queue
//  Description : Synchronous FIFO of fetch packets; flush beats push/pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
    import multicore_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type PKT_T = fetch_pkt_t
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  PKT_T                       i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output PKT_T                       o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    PKT_T               r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : PC owner and cache request sequencer with a decode queue.
//                Optional perf counters under macro IFETCH_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import multicore_pkg::*;
#(
    parameter int                   ADDR_SIZE   = 32,
    parameter logic [ADDR_SIZE-1:0] RESET_PC    = '0,
    parameter int                   QUEUE_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    output logic [ADDR_SIZE-1:0] o_addr,
    output logic                 o_req,
    input  logic                 i_req_ready,
    input  logic                 i_instr_valid,
    input  logic [INST_SIZE-1:0] i_instruction,
    input  logic                 i_redirect,
    input  logic [ADDR_SIZE-1:0] i_redirect_pc,
    output logic                 o_instr_valid,
    output logic [INST_SIZE-1:0] o_instr,
    output logic [ADDR_SIZE-1:0] o_pc,
    input  logic                 i_instr_ready
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]          o_perf_fetched,
    output logic [31:0]          o_perf_wait,
    output logic [31:0]          o_perf_discard
`endif
);

    localparam int                   c_CNT_W    = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [ADDR_SIZE-1:0] c_ALIGN    = ~ADDR_SIZE'(3);
    localparam logic [ADDR_SIZE-1:0] c_RESET_PC = RESET_PC & c_ALIGN;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] pc;
        logic [INST_SIZE-1:0] instr;
    } pkt_t;

    fetch_state_t         r_state, w_state_next;
    logic [ADDR_SIZE-1:0] r_pc, w_pc_next;
    logic [ADDR_SIZE-1:0] r_discard_addr, w_discard_next;
    logic [ADDR_SIZE-1:0] w_redirect_pc;
    logic [ADDR_SIZE-1:0] w_pc_inc;
    logic                 w_push, w_pop, w_flush, w_space;
    logic                 w_q_full, w_q_empty;
    logic [c_CNT_W-1:0]   w_q_count;
    pkt_t                 w_q_head, w_q_in;

    assign w_redirect_pc = i_redirect_pc & c_ALIGN;
    assign w_pc_inc      = r_pc + ADDR_SIZE'(4);
    assign w_push        = (r_state == WAIT_RSP) && i_instr_valid && !i_redirect;
    assign w_pop         = !w_q_empty && i_instr_ready;
    assign w_q_in        = '{pc: r_pc, instr: i_instruction};

    // Room for one more response after this cycle's push/pop settles,
    // i.e. count + push - pop stays below QUEUE_DEPTH.
    assign w_space = !((w_q_full && (w_push == w_pop)) ||
                       ((w_q_count == c_CNT_W'(QUEUE_DEPTH - 1)) && w_push && !w_pop));

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_discard_next = r_discard_addr;
        w_flush        = 1'b0;
        o_req          = 1'b0;
        o_addr         = r_pc;
        case (r_state)
            IDLE: begin
                o_req = w_space && i_req_ready && !i_redirect;
                if (i_redirect) begin
                    w_pc_next = w_redirect_pc;
                    w_flush   = 1'b1;
                end else if (o_req) begin
                    w_state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (i_redirect) begin
                    w_pc_next      = w_redirect_pc;
                    w_flush        = 1'b1;
                    w_discard_next = r_pc;
                    w_state_next   = i_instr_valid ? IDLE : DISCARD;
                end else if (i_instr_valid) begin
                    // Next address goes out in the hit's tag-check cycle.
                    o_addr       = w_pc_inc;
                    o_req        = w_space;
                    w_pc_next    = w_pc_inc;
                    w_state_next = w_space ? WAIT_RSP : IDLE;
                end
            end
            DISCARD: begin
                o_addr = r_discard_addr;
                if (i_redirect) begin
                    w_pc_next = w_redirect_pc;
                    w_flush   = 1'b1;
                end
                if (i_instr_valid) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_pc           <= c_RESET_PC;
            r_discard_addr <= c_RESET_PC;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_discard_addr <= w_discard_next;
        end
    end

    instr_fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .PKT_T (pkt_t)
    ) u_queue (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  (w_q_in),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_q_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

    assign o_instr_valid = !w_q_empty;
    assign o_instr       = w_q_head.instr;
    assign o_pc          = w_q_head.pc;

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_fetched, r_perf_wait, r_perf_discard;
    logic        w_wait_evt, w_drop_evt;

    assign w_wait_evt = (r_state == WAIT_RSP) && !i_instr_valid;
    assign w_drop_evt = i_instr_valid &&
                        (((r_state == WAIT_RSP) && i_redirect) || (r_state == DISCARD));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_perf_fetched <= '0;
            r_perf_wait    <= '0;
            r_perf_discard <= '0;
        end else begin
            r_perf_fetched <= sat_inc(r_perf_fetched, w_push);
            r_perf_wait    <= sat_inc(r_perf_wait, w_wait_evt);
            r_perf_discard <= sat_inc(r_perf_discard, w_drop_evt);
        end
    end

    assign o_perf_fetched = r_perf_fetched;
    assign o_perf_wait    = r_perf_wait;
    assign o_perf_discard = r_perf_discard;
`endif

endmodule
`default_nettype wire
